// File: rtl/seq_minterm_detector_pkg.sv
// Shared definitions for the sequential minterm detector: input modes, FSM state
// encodings and the default truth table.
package seq_minterm_detector_pkg;

    localparam logic MODE_PAR = 1'b0;
    localparam logic MODE_SER = 1'b1;

    // Minterms 2,5,7,11,13,14 of a 4-input function.
    localparam logic [15:0] DEFAULT_TT_N4 = 16'h68A4;

    typedef enum logic [1:0] {
        ST_PAR      = 2'd0,
        ST_SER_FILL = 2'd1,
        ST_SER_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_minterm_detector_if.sv
// Beat, table-write and result signals of the minterm detector, bundled with
// master (stimulus side) and slave (detector side) views.
interface seq_minterm_detector_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
);
    logic             mode;
    logic             in_valid;
    logic [N-1:0]     in_vec;
    logic             in_bit;
    logic             tt_we;
    logic [N-1:0]     tt_addr;
    logic             tt_data;
    logic             clr_count;
    logic             f;
    logic             f_valid;
    logic             window_full;
    logic [CNT_W-1:0] hit_count;

    modport master (
        output mode, in_valid, in_vec, in_bit, tt_we, tt_addr, tt_data, clr_count,
        input  f, f_valid, window_full, hit_count
    );

    modport slave (
        input  mode, in_valid, in_vec, in_bit, tt_we, tt_addr, tt_data, clr_count,
        output f, f_valid, window_full, hit_count
    );
endinterface

// File: rtl/seq_minterm_detector_tt_lut.sv
// Run-time writable truth table: one bit per minterm, one write port and one
// combinational read port; a read in the write cycle sees the old contents.
module seq_minterm_detector_tt_lut
    import seq_minterm_detector_pkg::*;
#(
    parameter int unsigned       N          = 4,
    parameter logic [(2**N)-1:0] DEFAULT_TT = DEFAULT_TT_N4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [N-1:0] waddr,
    input  logic         wdata,
    input  logic [N-1:0] raddr,
    output logic         rdata
);

    logic [(2**N)-1:0] table_r;

    // Table storage: reset restores the default function, otherwise single-bit writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            table_r <= DEFAULT_TT;
        end else if (we) begin
            table_r[waddr] <= wdata;
        end else begin
            table_r <= table_r;
        end
    end

    assign rdata = table_r[raddr];

endmodule

// File: rtl/seq_minterm_detector.sv
// Programmable N-input minterm detector: parallel or sliding-window serial evaluation
// against a writable truth table, with registered result and saturating hit counter.
module seq_minterm_detector
    import seq_minterm_detector_pkg::*;
#(
    parameter int unsigned       N          = 4,
    parameter logic [(2**N)-1:0] DEFAULT_TT = DEFAULT_TT_N4,
    parameter int unsigned       CNT_W      = 8
) (
    input logic                   clk,
    input logic                   rst,
    seq_minterm_detector_if.slave bus
);

    localparam int unsigned       FILL_W    = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_r;
    logic [N-2:0]      sr_r;
    logic [FILL_W-1:0] fill_r;
    logic              f_r;
    logic              f_valid_r;
    logic              window_full_r;
    logic [CNT_W-1:0]  hit_count_r;

    state_e            state_nxt_s;
    logic [N-2:0]      sr_nxt_s;
    logic [FILL_W-1:0] fill_nxt_s;
    logic              f_nxt_s;
    logic              f_valid_nxt_s;
    logic [CNT_W-1:0]  hit_count_nxt_s;
    logic [N-1:0]      win_s;
    logic [N-1:0]      rd_addr_s;
    logic              tt_rd_s;
    logic              fill_ready_s;
    logic [FILL_W-1:0] fill_inc_s;

    seq_minterm_detector_tt_lut #(
        .N          (N),
        .DEFAULT_TT (DEFAULT_TT)
    ) u_tt_lut (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.tt_we),
        .waddr (bus.tt_addr),
        .wdata (bus.tt_data),
        .raddr (rd_addr_s),
        .rdata (tt_rd_s)
    );

    // Window assembly and table address select; newest serial bit is the LSB.
    always_comb begin
        win_s        = {sr_r, bus.in_bit};
        fill_ready_s = (fill_r >= FILL_LAST);
        if (fill_ready_s) begin
            fill_inc_s = FILL_FULL;
        end else begin
            fill_inc_s = fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
        end
        if (bus.mode == MODE_PAR) begin
            rd_addr_s = bus.in_vec;
        end else begin
            rd_addr_s = win_s;
        end
    end

    // Next-state and next-output computation. PAR always leaves the shift register and
    // fill cleared, so the first serial beat after a mode switch starts a fresh window.
    always_comb begin
        state_nxt_s   = state_r;
        sr_nxt_s      = sr_r;
        fill_nxt_s    = fill_r;
        f_nxt_s       = f_r;
        f_valid_nxt_s = 1'b0;
        if (bus.mode == MODE_PAR) begin
            state_nxt_s = ST_PAR;
            sr_nxt_s    = {(N-1){1'b0}};
            fill_nxt_s  = {FILL_W{1'b0}};
            if (bus.in_valid) begin
                f_nxt_s       = tt_rd_s;
                f_valid_nxt_s = 1'b1;
            end else begin
                f_valid_nxt_s = 1'b0;
            end
        end else begin
            if (bus.in_valid) begin
                sr_nxt_s   = win_s[N-2:0];
                fill_nxt_s = fill_inc_s;
                if (fill_ready_s) begin
                    f_nxt_s       = tt_rd_s;
                    f_valid_nxt_s = 1'b1;
                end else begin
                    f_valid_nxt_s = 1'b0;
                end
            end else begin
                f_valid_nxt_s = 1'b0;
            end
            if (fill_nxt_s == FILL_FULL) begin
                state_nxt_s = ST_SER_RUN;
            end else begin
                state_nxt_s = ST_SER_FILL;
            end
        end
    end

    // Hit counter: clear wins over a same-cycle hit; saturates instead of wrapping.
    always_comb begin
        hit_count_nxt_s = hit_count_r;
        if (bus.clr_count) begin
            hit_count_nxt_s = {CNT_W{1'b0}};
        end else if (f_valid_nxt_s && f_nxt_s && (hit_count_r != CNT_MAX)) begin
            hit_count_nxt_s = hit_count_r + CNT_ONE;
        end else begin
            hit_count_nxt_s = hit_count_r;
        end
    end

    // FSM, window state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_PAR;
            sr_r          <= {(N-1){1'b0}};
            fill_r        <= {FILL_W{1'b0}};
            f_r           <= 1'b0;
            f_valid_r     <= 1'b0;
            window_full_r <= 1'b0;
            hit_count_r   <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            sr_r          <= sr_nxt_s;
            fill_r        <= fill_nxt_s;
            f_r           <= f_nxt_s;
            f_valid_r     <= f_valid_nxt_s;
            window_full_r <= (state_nxt_s == ST_SER_RUN);
            hit_count_r   <= hit_count_nxt_s;
        end
    end

    assign bus.f           = f_r;
    assign bus.f_valid     = f_valid_r;
    assign bus.window_full = window_full_r;
    assign bus.hit_count   = hit_count_r;

endmodule

// File: tb/tb_seq_minterm_detector.sv
// Directed self-checking bench for seq_minterm_detector: a default instance (CNT_W=8)
// and a narrow-counter instance (CNT_W=3) sharing clock and reset.
module tb_seq_minterm_detector;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    seq_minterm_detector_if #(.N(4), .CNT_W(8)) bus_a ();
    seq_minterm_detector_if #(.N(4), .CNT_W(3)) bus_b ();

    seq_minterm_detector #(.N(4), .DEFAULT_TT(16'h68A4), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    seq_minterm_detector #(.N(4), .DEFAULT_TT(16'h68A4), .CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec = n_vec + 1;
        if (obs != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.mode = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_vec = 4'd0; bus_a.in_bit = 1'b0;
        bus_a.tt_we = 1'b0; bus_a.tt_addr = 4'd0; bus_a.tt_data = 1'b0; bus_a.clr_count = 1'b0;
    endtask

    task automatic idle_b();
        bus_b.mode = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_vec = 4'd0; bus_b.in_bit = 1'b0;
        bus_b.tt_we = 1'b0; bus_b.tt_addr = 4'd0; bus_b.tt_data = 1'b0; bus_b.clr_count = 1'b0;
    endtask

    // Parallel sweep of all 16 minterms against the default table.
    task automatic sweep(input string tag, input int exp_hits);
        logic [15:0] tt_ref;
        tt_ref = 16'h68A4;
        bus_a.mode = 1'b0;
        bus_a.in_valid = 1'b1;
        for (int v = 0; v < 16; v++) begin
            bus_a.in_vec = 4'(v);
            tick();
            check_eq($sformatf("%s_f%0d", tag, v), int'(bus_a.f), int'(tt_ref[v]));
            check_eq($sformatf("%s_fv%0d", tag, v), int'(bus_a.f_valid), 1);
        end
        bus_a.in_valid = 1'b0;
        tick();
        check_eq({tag, "_fv_idle"}, int'(bus_a.f_valid), 0);
        check_eq({tag, "_hits"}, int'(bus_a.hit_count), exp_hits);
    endtask

    // One serial beat followed by checks of the strobe, window flag and (if strobed) f.
    task automatic feed(input string tag, input logic b, input int exp_fv, input int exp_wf,
                        input int exp_f);
        bus_a.mode = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.in_bit = b;
        tick();
        check_eq({tag, "_fv"}, int'(bus_a.f_valid), exp_fv);
        check_eq({tag, "_wf"}, int'(bus_a.window_full), exp_wf);
        if (exp_fv == 1) begin
            check_eq({tag, "_f"}, int'(bus_a.f), exp_f);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_a();
        idle_b();
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_f", int'(bus_a.f), 0);
        check_eq("rst_fv", int'(bus_a.f_valid), 0);
        check_eq("rst_wf", int'(bus_a.window_full), 0);
        check_eq("rst_hc", int'(bus_a.hit_count), 0);
        check_eq("rst_hc_b", int'(bus_b.hit_count), 0);

        // Default table sweep.
        sweep("sweep1", 6);

        // Table write uses pre-write table in the same cycle.
        bus_a.mode = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_vec = 4'd0;
        bus_a.tt_we = 1'b1; bus_a.tt_addr = 4'd0; bus_a.tt_data = 1'b1;
        tick();
        check_eq("wr_same_f", int'(bus_a.f), 0);
        bus_a.tt_we = 1'b0;
        tick();
        check_eq("wr_next_f", int'(bus_a.f), 1);
        check_eq("wr_next_hc", int'(bus_a.hit_count), 7);
        bus_a.in_valid = 1'b0;
        tick();

        // Serial windows 0101, 1011, 0110.
        feed("ser_b1", 1'b0, 0, 0, 0);
        feed("ser_b2", 1'b1, 0, 0, 0);
        feed("ser_b3", 1'b0, 0, 0, 0);
        feed("ser_b4", 1'b1, 1, 1, 1);
        feed("ser_b5", 1'b1, 1, 1, 1);
        feed("ser_b6", 1'b0, 1, 1, 0);
        check_eq("ser_hc", int'(bus_a.hit_count), 9);

        // Mode drop restarts the window.
        bus_a.mode = 1'b0; bus_a.in_valid = 1'b0;
        tick();
        check_eq("sw_par_wf", int'(bus_a.window_full), 0);
        feed("sw_a1", 1'b1, 0, 0, 0);
        feed("sw_a2", 1'b1, 0, 0, 0);
        bus_a.mode = 1'b0; bus_a.in_valid = 1'b0;
        tick();
        check_eq("sw_gap_wf", int'(bus_a.window_full), 0);
        check_eq("sw_gap_fv", int'(bus_a.f_valid), 0);
        feed("sw_b1", 1'b1, 0, 0, 0);
        feed("sw_b2", 1'b1, 0, 0, 0);
        feed("sw_b3", 1'b1, 0, 0, 0);
        feed("sw_b4", 1'b0, 1, 1, 1);
        bus_a.in_valid = 1'b0;
        tick();
        check_eq("sw_idle_fv", int'(bus_a.f_valid), 0);
        check_eq("sw_idle_f", int'(bus_a.f), 1);
        check_eq("sw_idle_wf", int'(bus_a.window_full), 1);
        check_eq("sw_hc", int'(bus_a.hit_count), 10);

        // A mode=0 beat straight out of serial is evaluated in parallel.
        bus_a.mode = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_vec = 4'd3;
        tick();
        check_eq("par_ret_f", int'(bus_a.f), 0);
        check_eq("par_ret_fv", int'(bus_a.f_valid), 1);
        check_eq("par_ret_wf", int'(bus_a.window_full), 0);
        bus_a.in_vec = 4'd13;
        tick();
        check_eq("par_13_f", int'(bus_a.f), 1);
        bus_a.in_valid = 1'b0;
        tick();
        check_eq("hold_f", int'(bus_a.f), 1);
        check_eq("hold_fv", int'(bus_a.f_valid), 0);
        check_eq("hold_hc", int'(bus_a.hit_count), 11);

        // Narrow counter saturation and clear priority.
        bus_b.mode = 1'b0; bus_b.in_valid = 1'b1; bus_b.in_vec = 4'd2;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 5) begin
                check_eq("sat_hc6", int'(bus_b.hit_count), 6);
            end
        end
        check_eq("sat_hc9", int'(bus_b.hit_count), 7);
        bus_b.clr_count = 1'b1;
        tick();
        check_eq("clr_hc", int'(bus_b.hit_count), 0);
        check_eq("clr_f", int'(bus_b.f), 1);
        bus_b.clr_count = 1'b0;
        tick();
        check_eq("post_clr_hc", int'(bus_b.hit_count), 1);
        idle_b();

        // Zero the table, go serial, then reset mid-stream with conflicting inputs.
        bus_a.mode = 1'b0; bus_a.in_valid = 1'b0; bus_a.tt_we = 1'b1; bus_a.tt_data = 1'b0;
        for (int a = 0; a < 16; a++) begin
            bus_a.tt_addr = 4'(a);
            tick();
        end
        bus_a.tt_we = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_vec = 4'd5;
        tick();
        check_eq("zero_f5", int'(bus_a.f), 0);
        feed("zs_b1", 1'b1, 0, 0, 0);
        feed("zs_b2", 1'b0, 0, 0, 0);
        feed("zs_b3", 1'b1, 0, 0, 0);
        feed("zs_b4", 1'b1, 1, 1, 0);
        check_eq("zs_hc", int'(bus_a.hit_count), 11);
        rst = 1'b1;
        bus_a.in_bit = 1'b1;
        bus_a.tt_we = 1'b1; bus_a.tt_addr = 4'd2; bus_a.tt_data = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("rst2_f", int'(bus_a.f), 0);
        check_eq("rst2_fv", int'(bus_a.f_valid), 0);
        check_eq("rst2_wf", int'(bus_a.window_full), 0);
        check_eq("rst2_hc", int'(bus_a.hit_count), 0);
        idle_a();
        sweep("sweep2", 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
